// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper : gameplay score accumulator with saturation, high score and
//                one-shot extra-life pulse for the on-screen text renderer.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_keeper_pkg;
  typedef enum logic [2:0] {
    GAME_MODE_LOADING    = 3'd0,
    GAME_MODE_READY      = 3'd1,
    GAME_MODE_PLAYING    = 3'd2,
    GAME_MODE_DYING      = 3'd3,
    GAME_MODE_LEVEL_DONE = 3'd4,
    GAME_MODE_GAME_OVER  = 3'd5
  } game_mode_t;
endpackage

module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int SCORE_MAX      = 9999,
  parameter int PELLET_PTS     = 10,
  parameter int POWER_PTS      = 50,
  parameter int GHOST_BASE_PTS = 200,
  parameter int EXTRA_LIFE_AT  = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  game_mode_t  MODE,
  input  logic        new_game,
  input  logic        ate_pellet,
  input  logic        ate_power,
  input  logic        ate_ghost,
  input  logic        power_end,
  input  logic        ate_fruit,
  input  logic [11:0] fruit_pts,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [1:0]  ghost_chain,
  output logic        extra_life
);

  localparam logic [16:0] SCORE_MAX_W  = 17'(SCORE_MAX);
  localparam logic [16:0] PELLET_W     = 17'(PELLET_PTS);
  localparam logic [16:0] POWER_W      = 17'(POWER_PTS);
  localparam logic [16:0] GHOST_BASE_W = 17'(GHOST_BASE_PTS);
  localparam logic [15:0] EXTRA_LIFE_W = 16'(EXTRA_LIFE_AT);

  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic [1:0]  chain_q, chain_d;
  logic        life_awarded_q, life_awarded_d;
  logic        extra_life_q, extra_life_d;

  logic        accept;
  logic [16:0] inc;
  logic [16:0] sum;

  always_comb begin
    accept = (MODE != GAME_MODE_LOADING) && (MODE != GAME_MODE_READY);

    inc = '0;
    if (accept) begin
      if (ate_pellet) inc = inc + PELLET_W;
      if (ate_power)  inc = inc + POWER_W;
      // Ghost value uses the chain before any same-cycle clear.
      if (ate_ghost)  inc = inc + (GHOST_BASE_W << chain_q);
      if (ate_fruit)  inc = inc + {5'd0, fruit_pts};
    end

    sum     = {1'b0, score_q} + inc;
    score_d = (sum > SCORE_MAX_W) ? SCORE_MAX_W[15:0] : sum[15:0];

    chain_d = chain_q;
    if (accept) begin
      if (ate_power || power_end) begin
        chain_d = 2'd0;
      end else if (ate_ghost && (chain_q != 2'd3)) begin
        chain_d = chain_q + 2'd1;
      end
    end

    extra_life_d   = 1'b0;
    life_awarded_d = life_awarded_q;
    if (!life_awarded_q && (score_d >= EXTRA_LIFE_W)) begin
      extra_life_d   = 1'b1;
      life_awarded_d = 1'b1;
    end

    // Session high score trails score by one register stage.
    high_d = (score_q > high_q) ? score_q : high_q;

    if (new_game) begin
      score_d        = '0;
      chain_d        = '0;
      life_awarded_d = 1'b0;
      extra_life_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q        <= '0;
      high_q         <= '0;
      chain_q        <= '0;
      life_awarded_q <= 1'b0;
      extra_life_q   <= 1'b0;
    end else begin
      score_q        <= score_d;
      high_q         <= high_d;
      chain_q        <= chain_d;
      life_awarded_q <= life_awarded_d;
      extra_life_q   <= extra_life_d;
    end
  end

  assign score       = score_q;
  assign high_score  = high_q;
  assign ghost_chain = chain_q;
  assign extra_life  = extra_life_q;

endmodule

`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream stage of the on-screen text renderer. Produces the 16-bit binary `score` and `high_score` that the renderer converts to BCD and draws.
- Accumulates gameplay scoring events (pellet, power pellet, ghost chain, fruit) and saturates at the 4-digit display limit.
- Tracks the session high score and emits a one-shot extra-life pulse.

Parameters:
- SCORE_MAX, 9999, saturation ceiling (4 BCD digits on screen)
- PELLET_PTS, 10, points per pellet
- POWER_PTS, 50, points per power pellet
- GHOST_BASE_PTS, 200, points for first ghost in a chain; doubles per ghost
- EXTRA_LIFE_AT, 5000, score threshold for the extra-life pulse

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- MODE  in  game_mode_t  current game mode
- new_game  in  1  one-cycle pulse, starts a new game
- ate_pellet  in  1  one-cycle pulse
- ate_power  in  1  one-cycle pulse
- ate_ghost  in  1  one-cycle pulse
- power_end  in  1  one-cycle pulse, frightened period over
- ate_fruit  in  1  one-cycle pulse
- fruit_pts  in  12  points for the fruit, sampled with ate_fruit
- score  out  16  current score, binary, 0..SCORE_MAX
- high_score  out  16  session high score, binary
- ghost_chain  out  2  ghosts eaten in current power period, saturating at 3
- extra_life  out  1  one-cycle pulse on first threshold crossing per game

Behaviour:
- Reset (rst_n low, asynchronous): score=0, high_score=0, ghost_chain=0, extra_life=0, life_awarded flag=0. Release is synchronous to clk.
- Event gating: events are accepted only when MODE is neither GAME_MODE_LOADING nor GAME_MODE_READY. Gated events have no effect, including on chain state.
- Per-cycle increment `inc` is the sum of all accepted events in that cycle:
  - PELLET_PTS·ate_pellet
  - POWER_PTS·ate_power
  - (GHOST_BASE_PTS << ghost_chain)·ate_ghost, giving 200/400/800/1600
  - fruit_pts·ate_fruit
- Simultaneous events therefore add together.
- Width and saturation: compute `score + inc` at 17 bits. If the result exceeds SCORE_MAX, load SCORE_MAX. No wrap-around ever.
- Latency: an event in cycle N is visible on `score` in cycle N+1.
- Ghost chain:
  - ate_ghost increments ghost_chain, saturating at 3. A 4th and later ghost all score 1600.
  - ate_power or power_end clears ghost_chain to 0.
  - If ate_ghost coincides with ate_power or power_end, the ghost is scored with the pre-clear chain value and the chain ends at 0 (clear wins).
- High score: in cycle N+2, `high_score <= max(high_score, score)`, one register stage after `score`. It is never decreased except by reset.
- Extra life:
  - extra_life is high for exactly the one cycle in which `score` first becomes >= EXTRA_LIFE_AT, i.e. aligned with the score update.
  - It is then latched off via life_awarded until new_game.
  - A saturating jump straight past the threshold still pulses once.
- new_game:
  - Next cycle: score=0, ghost_chain=0, life_awarded=0, extra_life=0. high_score is retained.
  - new_game has priority over any event in the same cycle; those events are dropped.
- MODE change mid-game: score, chain and high_score hold. No implicit clear.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, MODE=playing, 3 ate_pellet pulses -> score 0→10→20→30, each one cycle after its pulse. high_score reaches 30 one cycle after score.
- ate_power then 5 ate_ghost pulses -> score +50, then +200, +400, +800, +1600, +1600. ghost_chain 1,2,3,3,3. A further power_end -> ghost_chain=0 with score unchanged.
- Same cycle: ate_pellet + ate_ghost (chain=1) + ate_fruit with fruit_pts=100 -> score increases by exactly 510 in one step. Same cycle ate_ghost + ate_power with chain=2 -> +850, chain=0.
- Score=9990, ate_fruit fruit_pts=700 -> score=9999. Then ate_pellet -> stays 9999.
- Score=4990, ate_fruit with fruit_pts=3000 -> score=7990 and extra_life high for exactly 1 cycle. Further crossings give no pulse. new_game, then re-cross 5000 -> pulses again, and high_score keeps 7990 across the new_game.
- MODE=GAME_MODE_READY with all events pulsing -> score unchanged. Assert rst_n low mid-game, asynchronously between clock edges -> all outputs 0 immediately.
